// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared constants, tag-stage types and forwarding-select decode for the
// EX-stage forwarding / load-use hazard controller.
package fwd_hazard_ctrl_pkg;

  localparam int unsigned REG_W = 5;

  localparam logic [1:0]       FW_IDEX  = 2'b00;
  localparam logic [1:0]       FW_MEMWB = 2'b01;
  localparam logic [1:0]       FW_EXMEM = 2'b10;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] wr;
    logic             regwrite;
    logic             memread;
  } ex_tag_t;

  typedef struct packed {
    logic [REG_W-1:0] wr;
    logic             regwrite;
  } wb_tag_t;

  // Nearest producer wins: an EX/MEM hit shadows a MEM/WB hit.
  function automatic logic [1:0] fw_sel_decode(input logic mem_hit, input logic wb_hit);
    if (mem_hit)     return FW_EXMEM;
    else if (wb_hit) return FW_MEMWB;
    else             return FW_IDEX;
  endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_src_sel.sv
// Forwarding-source select for one EX operand; purely combinational.
module fwd_src_sel
  import fwd_hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] ex_idx_i,
  input  logic [REG_W-1:0] mem_wr_i,
  input  logic             mem_regwrite_i,
  input  logic [REG_W-1:0] wb_wr_i,
  input  logic             wb_regwrite_i,
  output logic [1:0]       sel_o
);

  logic mem_hit;
  logic wb_hit;

  always_comb begin
    mem_hit = mem_regwrite_i && (mem_wr_i != REG_ZERO) && (mem_wr_i == ex_idx_i);
    wb_hit  = wb_regwrite_i  && (wb_wr_i  != REG_ZERO) && (wb_wr_i  == ex_idx_i);
    sel_o   = fw_sel_decode(mem_hit, wb_hit);
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Tracks register tags through EX/MEM/WB, drives EX forwarding selects and
// detects load-use hazards against the instruction currently in ID.
module fwd_hazard_ctrl
  import fwd_hazard_ctrl_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic [REG_W-1:0] id_wr_i,
  input  logic             id_regwrite_i,
  input  logic             id_memread_i,
  input  logic             flush_i,
  output logic [1:0]       fwA_o,
  output logic [1:0]       fwB_o,
  output logic             stall_o
);

  ex_tag_t ex_q,  ex_d;
  wb_tag_t mem_q, mem_d;
  wb_tag_t wb_q,  wb_d;

  always_comb begin
    stall_o = ex_q.memread && (ex_q.wr != REG_ZERO) &&
              ((ex_q.wr == id_rs_i) || (ex_q.wr == id_rt_i));
  end

  always_comb begin
    ex_d  = '0;
    if (!(stall_o || flush_i)) begin
      ex_d.rs       = id_rs_i;
      ex_d.rt       = id_rt_i;
      ex_d.wr       = id_wr_i;
      ex_d.regwrite = id_regwrite_i;
      ex_d.memread  = id_memread_i;
    end
    mem_d.wr       = ex_q.wr;
    mem_d.regwrite = ex_q.regwrite;
    wb_d           = mem_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  fwd_src_sel u_sel_a (
    .ex_idx_i       (ex_q.rs),
    .mem_wr_i       (mem_q.wr),
    .mem_regwrite_i (mem_q.regwrite),
    .wb_wr_i        (wb_q.wr),
    .wb_regwrite_i  (wb_q.regwrite),
    .sel_o          (fwA_o)
  );

  fwd_src_sel u_sel_b (
    .ex_idx_i       (ex_q.rt),
    .mem_wr_i       (mem_q.wr),
    .mem_regwrite_i (mem_q.regwrite),
    .wb_wr_i        (wb_q.wr),
    .wb_regwrite_i  (wb_q.regwrite),
    .sel_o          (fwB_o)
  );

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl: directed pipeline scenarios plus
// randomized instruction streams against an instruction-history model.
module tb_fwd_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, id_wr;
  logic       id_rw, id_mr, flush;
  logic [1:0] fwA, fwB;
  logic       stall;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int rs; int rt; int wr; bit rw; bit mr;
  } instr_t;

  // Model: hist[0] is the instruction in EX, hist[1] one older (MEM), hist[2] (WB).
  instr_t hist [3];

  always #5 clk = ~clk;

  fwd_hazard_ctrl dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .id_rs_i       (id_rs),
    .id_rt_i       (id_rt),
    .id_wr_i       (id_wr),
    .id_regwrite_i (id_rw),
    .id_memread_i  (id_mr),
    .flush_i       (flush),
    .fwA_o         (fwA),
    .fwB_o         (fwB),
    .stall_o       (stall)
  );

  function automatic instr_t nop();
    instr_t n;
    n.rs = 0; n.rt = 0; n.wr = 0; n.rw = 0; n.mr = 0;
    return n;
  endfunction

  function automatic void clear_model();
    for (int i = 0; i < 3; i++) hist[i] = nop();
  endfunction

  function automatic bit exp_stall();
    return hist[0].mr && hist[0].wr != 0 &&
           (hist[0].wr == int'(id_rs) || hist[0].wr == int'(id_rt));
  endfunction

  // Search older instructions from nearest to farthest for a producer.
  function automatic logic [1:0] exp_fw(input int r);
    if (r == 0) return 2'b00;
    for (int age = 1; age <= 2; age++)
      if (hist[age].rw && hist[age].wr == r) return (age == 1) ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  task automatic drive(input int rs, input int rt, input int wr, input bit rw,
                       input bit mr, input bit fl);
    id_rs = 5'(rs); id_rt = 5'(rt); id_wr = 5'(wr);
    id_rw = rw; id_mr = mr; flush = fl;
    #1;
  endtask

  task automatic tick();
    bit     s;
    instr_t n;
    s = exp_stall();
    n.rs = int'(id_rs); n.rt = int'(id_rt); n.wr = int'(id_wr);
    n.rw = id_rw; n.mr = id_mr;
    @(posedge clk);
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = (s || flush) ? nop() : n;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(4, 4, 4, 1, 1, 0);
    @(posedge clk); #1;
    clear_model();
    checks++; if (fwA !== 2'b00) begin failures++; $display("FAIL reset_fwA got=%b exp=00", fwA); end
    checks++; if (fwB !== 2'b00) begin failures++; $display("FAIL reset_fwB got=%b exp=00", fwB); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) tick();
  endtask

  task automatic test_back_to_back();
    drive(1, 2, 3, 1, 0, 0); tick();          // add $3
    drive(3, 6, 8, 1, 0, 0); tick();          // sub rs=3
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (fwA !== 2'b10) begin failures++; $display("FAIL b2b_fwA got=%b exp=10", fwA); end
    checks++; if (fwB !== 2'b00) begin failures++; $display("FAIL b2b_fwB got=%b exp=00", fwB); end
    repeat (3) tick();
  endtask

  task automatic test_gap();
    drive(1, 2, 3, 1, 0, 0); tick();          // add $3
    drive(0, 0, 0, 0, 0, 0); tick();          // nop
    drive(9, 3, 10, 1, 0, 0); tick();         // or rt=3
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (fwB !== 2'b01) begin failures++; $display("FAIL gap_fwB got=%b exp=01", fwB); end
    checks++; if (fwA !== 2'b00) begin failures++; $display("FAIL gap_fwA got=%b exp=00", fwA); end
    repeat (3) tick();
  endtask

  task automatic test_double_match();
    drive(1, 0, 5, 1, 0, 0); tick();
    drive(5, 0, 5, 1, 0, 0); tick();
    drive(5, 5, 6, 1, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (fwA !== 2'b10) begin failures++; $display("FAIL dbl_fwA got=%b exp=10", fwA); end
    checks++; if (fwB !== 2'b10) begin failures++; $display("FAIL dbl_fwB got=%b exp=10", fwB); end
    repeat (3) tick();
  endtask

  task automatic test_load_use();
    drive(2, 0, 4, 1, 1, 0); tick();          // lw $4
    drive(4, 1, 11, 1, 0, 0);                 // add rs=4 held in ID
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL lu_stall1 got=%b exp=1", stall); end
    tick();
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL lu_stall2 got=%b exp=0", stall); end
    checks++; if (fwA !== 2'b00) begin failures++; $display("FAIL lu_bubble_fwA got=%b exp=00", fwA); end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (fwA !== 2'b01) begin failures++; $display("FAIL lu_fwA got=%b exp=01", fwA); end
    repeat (3) tick();
  endtask

  task automatic test_zero_flush();
    drive(1, 2, 0, 1, 1, 0); tick();          // load to $0
    drive(0, 0, 12, 1, 0, 0);
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL zero_stall got=%b exp=0", stall); end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (fwA !== 2'b00 || fwB !== 2'b00) begin
      failures++; $display("FAIL zero_fw got=%b/%b exp=00/00", fwA, fwB); end
    repeat (3) tick();
    drive(1, 2, 7, 1, 1, 1); tick();          // flushed lw $7
    drive(7, 7, 13, 1, 0, 0);
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL flush_stall got=%b exp=0", stall); end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (fwA !== 2'b00 || fwB !== 2'b00) begin
      failures++; $display("FAIL flush_fw got=%b/%b exp=00/00", fwA, fwB); end
    repeat (3) tick();
  endtask

  task automatic test_reset_mid();
    drive(1, 2, 3, 1, 0, 0); tick();
    drive(1, 2, 6, 1, 1, 0); tick();          // lw $6, MEM holds $3 producer
    drive(6, 3, 9, 1, 0, 0);
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL rm_pre_stall got=%b exp=1", stall); end
    rst = 1'b1; #1;
    clear_model();
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rm_stall got=%b exp=0", stall); end
    checks++; if (fwA !== 2'b00 || fwB !== 2'b00) begin
      failures++; $display("FAIL rm_fw got=%b/%b exp=00/00", fwA, fwB); end
    rst = 1'b0; #1;
    tick();                                   // ID instr loads into EX
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (fwA !== 2'b00 || fwB !== 2'b00) begin
      failures++; $display("FAIL rm_empty got=%b/%b exp=00/00", fwA, fwB); end
    repeat (3) tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 9) == 0));
      checks++; if (stall !== exp_stall()) begin
        failures++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", i, stall, exp_stall()); end
      checks++; if (fwA !== exp_fw(hist[0].rs)) begin
        failures++; $display("FAIL rnd_fwA cyc=%0d got=%b exp=%b", i, fwA, exp_fw(hist[0].rs)); end
      checks++; if (fwB !== exp_fw(hist[0].rt)) begin
        failures++; $display("FAIL rnd_fwB cyc=%0d got=%b exp=%b", i, fwB, exp_fw(hist[0].rt)); end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_model();
    drive(0, 0, 0, 0, 0, 0);
    test_reset();
    test_back_to_back();
    test_gap();
    test_double_match();
    test_load_use();
    test_zero_flush();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
